wifi_status_pio_in: RTL and testbench
=====================================

# wifi_status_pio_in

Avalon-MM slave input port that samples asynchronous status pins from the Wi-Fi module, such as ready and link-up, into the CPEN391 Computer clock domain. It is the read-side counterpart of the single-bit output PIOs that drive the module's control pins. Its functions:
- synchronises each pin;
- detects edges per a compile-time policy;
- latches them in a sticky edge-capture register;
- raises a maskable level interrupt to the HPS/Nios.

## Interface
Parameters:
- WIDTH, 4, number of input pins (1–32).
- EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address within the slave.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  read data; combinational from address, zero wait states; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous pins from the Wi-Fi module.
- irq  out  1  level interrupt, active-high.

## Operation
Register map (word addresses):
- 0 DATA (RO): synchronised pin value; writes are ignored.
- 1 reserved: reads 0; writes are ignored.
- 2 IRQMASK (RW): per-bit interrupt enable.
- 3 EDGECAP (R/W1C): sticky edge flags. Writing 1 to a bit clears it; writing 0 has no effect.

Synchronisation and edge detection:
- Each pin passes through a 2-flop synchroniser (s1 then s2). A previous-value register, prev, holds the last s2 value.
- Edge condition per bit:
  - rising: s2 & ~prev
  - falling: ~s2 & prev
  - any: s2 ^ prev
- A 2-bit arm counter holds detection disabled for the first 3 clocks after reset deasserts. This suppresses spurious edges from pins already high at reset; it saturates at 3, and detection is enabled when it reaches 3.
- An armed edge condition sets the corresponding EDGECAP bit on the next clock edge.

Write and interrupt behaviour:
- A write takes effect when chipselect and ~write_n are both true at a clk rising edge.
- A write to EDGECAP in the same cycle that a new edge is detected on that bit leaves the bit set; set wins.
- irq = OR-reduction of (EDGECAP & IRQMASK). It is combinational from registers and stays high until software clears the flags or the mask.

Reset (asynchronous, immediate): s1, s2, prev, IRQMASK, EDGECAP and the arm counter all clear to 0. As a result, readdata at address 0 reads 0 and irq is 0.

## Timing
- Pin to DATA: a pin change is visible in DATA after the 2nd rising clk edge following the change, 3 edges worst case including metastability resolution.
- Pin to EDGECAP/irq: the edge is captured on the 3rd rising edge after the change; irq asserts in the same cycle that the EDGECAP bit reads 1.
- Register writes: IRQMASK and EDGECAP writes take effect on the write edge. The new value is visible on readdata and irq in the following cycle.
- Pulse width: pulses shorter than one clk period may be missed; pins must be held ≥ 2 clk periods to be guaranteed captured.
- Reset mid-operation: all state clears asynchronously, and the arm counter restarts its 3-clock window after deassertion.

## Structure
- Shared package holds:
  - register address constants: ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3;
  - EDGE_TYPE encodings: EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
- One sub-module, `sync_2ff`: parameterised WIDTH, ports clk, reset, d, q. It contains the two synchroniser flops and is reusable by other input PIOs.
- Top level contains the arm counter, prev, edge logic, the IRQMASK and EDGECAP registers, the read mux and irq.

## Test plan
- Reset value: assert reset with in_port = 4'hF, then release. Read DATA after 4 clks → 0xF. EDGECAP reads 0 and irq stays 0, because the arm window suppresses the edge.
- Rising edge, EDGE_TYPE = 0: write IRQMASK = 0x1, then drive in_port[0] 0→1.
  - EDGECAP = 0x1 and irq = 1 on the 3rd edge after the change.
  - Driving 1→0 adds no flag.
- W1C clear: with EDGECAP = 0x5, write 0x4 to address 3 → EDGECAP = 0x1; write 0x1 → EDGECAP = 0 and irq deasserts the next cycle.
- Simultaneous set and clear: time a W1C write of 0x2 to coincide with the edge-detect cycle on bit 1 → EDGECAP[1] stays 1.
- Mask gating: EDGECAP = 0x8 with IRQMASK = 0 → irq = 0. Write IRQMASK = 0x8 → irq = 1 the next cycle.
- EDGE_TYPE = 2 instance: a 1→0→1 toggle on bit 2, each level held 4 clks, → EDGECAP[2] = 1. Address 1 read → 0, and a write to DATA leaves DATA unchanged.

Source files
------------

// File: rtl/wifi_status_pio_in_pkg.sv
// Shared definitions for the Wi-Fi status input PIO: register word
// addresses, edge-policy encodings and the edge-detect helper.
package wifi_status_pio_in_pkg;

    // Register word addresses (address 1 is reserved)
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // EDGE_TYPE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Per-bit edge condition from the current and previous synchronised value.
    // Operates on a full 32-bit word; callers truncate to their pin count.
    function automatic logic [31:0] edge_detect(input int          edge_type,
                                                input logic [31:0] cur,
                                                input logic [31:0] last);
        case (edge_type)
            EDGE_RISE: return cur & ~last;
            EDGE_FALL: return ~cur & last;
            default:   return cur ^ last;
        endcase
    endfunction

endpackage

// File: rtl/wifi_status_pio_in_if.sv
// Avalon-MM slave bus of the status PIO.
// Handshake: a write is accepted on any clk rising edge where chipselect is 1
// and write_n is 0 (no wait states, no backpressure); readdata is a pure
// combinational function of address and is valid in the same cycle.
interface wifi_status_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/wifi_status_pio_in_sync_2ff.sv
// Two-flop synchroniser bank for asynchronous input pins; reusable by any
// input PIO. q follows d two clk edges later.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // First stage may go metastable; second stage gives it a full cycle to settle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/wifi_status_pio_in.sv
// Avalon-MM input PIO for the Wi-Fi module status pins: synchronises the
// pins, captures edges into a sticky W1C register and raises a maskable
// level interrupt.
module wifi_status_pio_in
    import wifi_status_pio_in_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic                 clk,
    input  logic                 reset,
    wifi_status_pio_in_if.slave  bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_cond;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] wdata_w;
    logic [1:0]       arm_cnt;
    logic             armed;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_cap;
    logic [31:0]      rd_word;

    sync_2ff #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (s2)
    );

    // Write-data bits above the pin count are ignored
    assign wdata_w = bus.writedata[WIDTH-1:0];
    generate
        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign wr_mask = wr_en && (bus.address == ADDR_IRQMASK);
    assign wr_cap  = wr_en && (bus.address == ADDR_EDGECAP);

    // Arm window: keeps detection off for 3 clocks after reset so pins that
    // were already high do not look like fresh edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt <= 2'd0;
        end else if (arm_cnt != 2'd3) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign armed = (arm_cnt == 2'd3);

    // Previous synchronised value for edge comparison; tracks s2 even while unarmed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= '0;
        end else begin
            prev <= s2;
        end
    end

    assign edge_cond = WIDTH'(edge_detect(EDGE_TYPE, 32'(s2), 32'(prev)));

    // Next EDGECAP: W1C clear first, then armed edges set (set wins on collision)
    always_comb begin
        cap_clr  = '0;
        cap_set  = '0;
        if (wr_cap) begin
            cap_clr = wdata_w;
        end
        if (armed) begin
            cap_set = edge_cond;
        end
        cap_next = (edge_cap & ~cap_clr) | cap_set;
    end

    // Sticky edge-capture register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= cap_next;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr_mask) begin
            irq_mask <= wdata_w;
        end
    end

    // Read mux: zero-wait-state, unused upper bits and reserved address read 0
    always_comb begin
        rd_word = '0;
        case (bus.address)
            ADDR_DATA:    rd_word[WIDTH-1:0] = s2;
            ADDR_IRQMASK: rd_word[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rd_word[WIDTH-1:0] = edge_cap;
            default:      rd_word = '0;
        endcase
    end

    assign bus.readdata = rd_word;

    // Level interrupt held until flags or mask are cleared
    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_wifi_status_pio_in.sv
// Bench for wifi_status_pio_in: a rising-edge instance driven from a vector
// table plus hand sequences, and an any-edge instance for the toggle case.
module tb_wifi_status_pio_in;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wifi_status_pio_in_if bus_m ();
    wifi_status_pio_in_if bus_a ();

    logic [3:0] pins_m;
    logic [3:0] pins_a;
    logic       irq_m;
    logic       irq_a;

    wifi_status_pio_in #(.WIDTH(4), .EDGE_TYPE(0)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_m.slave),
        .in_port (pins_m),
        .irq     (irq_m)
    );

    wifi_status_pio_in #(.WIDTH(4), .EDGE_TYPE(2)) u_dut_any (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_a.slave),
        .in_port (pins_a),
        .irq     (irq_a)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got);
        logic [31:0] exp;
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        bus_m.address = 2'd0; bus_m.chipselect = 1'b0; bus_m.write_n = 1'b1; bus_m.writedata = '0;
        bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    endtask

    // Holds a write across exactly one rising edge, returns at the next falling edge
    task automatic bus_write(input bit sel, input logic [1:0] addr, input logic [31:0] data);
        if (!sel) begin
            bus_m.address = addr; bus_m.chipselect = 1'b1; bus_m.write_n = 1'b0; bus_m.writedata = data;
        end else begin
            bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0; bus_a.writedata = data;
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input bit sel, input logic [1:0] addr,
                            output logic [31:0] data, output logic irq_o);
        if (!sel) begin
            bus_m.address = addr; bus_m.chipselect = 1'b1; bus_m.write_n = 1'b1;
        end else begin
            bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
        end
        #1;
        data  = sel ? bus_a.readdata : bus_m.readdata;
        irq_o = sel ? irq_a : irq_m;
        bus_idle();
    endtask

    task automatic read_check(input bit sel, input logic [1:0] addr,
                              input logic [31:0] exp_rd, input logic exp_irq,
                              input string name);
        logic [31:0] rd;
        logic        iq;
        bus_read(sel, addr, rd, iq);
        exp_q.push_back(exp_rd);
        check({name, " rd"}, rd);
        exp_q.push_back({31'd0, exp_irq});
        check({name, " irq"}, {31'd0, iq});
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  pins;
        bit          do_wr;
        logic [1:0]  wr_addr;
        logic [31:0] wr_data;
        int          wait_n;
        logic [1:0]  rd_addr;
        logic [31:0] exp_rd;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // pins, wr?, waddr, wdata, wait, raddr, exp_rd, exp_irq, name
        vecs[0]  = '{4'h0, 1'b1, 2'd2, 32'h1,        3, 2'd2, 32'h1, 1'b0, "mask_wr_fall_no_cap"};
        vecs[1]  = '{4'h0, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h0, 1'b0, "fall_no_flag"};
        vecs[2]  = '{4'h0, 1'b0, 2'd0, 32'h0,        0, 2'd0, 32'h0, 1'b0, "data_low"};
        vecs[3]  = '{4'h1, 1'b0, 2'd0, 32'h0,        2, 2'd0, 32'h1, 1'b0, "data_after_2_edges"};
        vecs[4]  = '{4'h1, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h0, 1'b0, "cap_not_yet"};
        vecs[5]  = '{4'h1, 1'b0, 2'd0, 32'h0,        1, 2'd3, 32'h1, 1'b1, "cap_on_3rd_edge"};
        vecs[6]  = '{4'h0, 1'b0, 2'd0, 32'h0,        4, 2'd3, 32'h1, 1'b1, "fall_adds_nothing"};
        vecs[7]  = '{4'h4, 1'b0, 2'd0, 32'h0,        4, 2'd3, 32'h5, 1'b1, "cap_0x5"};
        vecs[8]  = '{4'h4, 1'b1, 2'd3, 32'h4,        0, 2'd3, 32'h1, 1'b1, "w1c_0x4"};
        vecs[9]  = '{4'h4, 1'b1, 2'd3, 32'h1,        0, 2'd3, 32'h0, 1'b0, "w1c_0x1_irq_drop"};
        vecs[10] = '{4'h4, 1'b1, 2'd2, 32'h0,        0, 2'd2, 32'h0, 1'b0, "mask_clear"};
        vecs[11] = '{4'hC, 1'b0, 2'd0, 32'h0,        4, 2'd3, 32'h8, 1'b0, "cap8_masked"};
        vecs[12] = '{4'hC, 1'b1, 2'd2, 32'h8,        0, 2'd3, 32'h8, 1'b1, "unmask_irq"};
        vecs[13] = '{4'hC, 1'b1, 2'd0, 32'h3,        0, 2'd0, 32'hC, 1'b1, "data_write_ignored"};
        vecs[14] = '{4'hC, 1'b1, 2'd1, 32'hFFFFFFFF, 0, 2'd1, 32'h0, 1'b1, "reserved_reads_0"};
        vecs[15] = '{4'hC, 1'b1, 2'd3, 32'h0,        0, 2'd3, 32'h8, 1'b1, "w1c_zero_no_effect"};
        vecs[16] = '{4'hC, 1'b1, 2'd2, 32'hFFFFFFF0, 0, 2'd2, 32'h0, 1'b0, "mask_upper_ignored"};
        vecs[17] = '{4'hC, 1'b1, 2'd3, 32'hFFFFFFF8, 0, 2'd3, 32'h0, 1'b0, "w1c_clear_bit3"};
    end

    // ---------------- test sequence ----------------
    initial begin
        bus_idle();
        pins_m = 4'hF;
        pins_a = 4'h4;
        reset  = 1'b1;

        // Reset state with pins already high
        wait_clks(3);
        read_check(0, 2'd0, 32'h0, 1'b0, "reset_data");
        read_check(0, 2'd3, 32'h0, 1'b0, "reset_cap");
        @(negedge clk);
        reset = 1'b0;
        wait_clks(4);
        read_check(0, 2'd0, 32'hF, 1'b0, "post_reset_data");
        read_check(0, 2'd3, 32'h0, 1'b0, "arm_suppresses_edge");

        // Table-driven vectors on the rising-edge instance
        for (int i = 0; i < 18; i++) begin
            pins_m = vecs[i].pins;
            if (vecs[i].do_wr) bus_write(0, vecs[i].wr_addr, vecs[i].wr_data);
            wait_clks(vecs[i].wait_n);
            read_check(0, vecs[i].rd_addr, vecs[i].exp_rd, vecs[i].exp_irq, vecs[i].name);
        end

        // Set and clear in the same cycle on bit 1: set wins
        @(negedge clk);
        pins_m = 4'hE;
        wait_clks(2);
        bus_write(0, 2'd3, 32'h2);
        read_check(0, 2'd3, 32'h2, 1'b0, "set_wins_over_clear");
        bus_write(0, 2'd3, 32'h2);
        read_check(0, 2'd3, 32'h0, 1'b0, "clear_after_collision");

        // Any-edge instance: 1->0->1 on bit 2, each level held 4 clocks
        read_check(1, 2'd3, 32'h0, 1'b0, "any_idle_cap");
        pins_a = 4'h0;
        wait_clks(4);
        read_check(1, 2'd3, 32'h4, 1'b0, "any_fall_captured");
        bus_write(1, 2'd2, 32'h4);
        read_check(1, 2'd2, 32'h4, 1'b1, "any_mask_irq");
        bus_write(1, 2'd3, 32'h4);
        read_check(1, 2'd3, 32'h0, 1'b0, "any_w1c");
        pins_a = 4'h4;
        wait_clks(4);
        read_check(1, 2'd3, 32'h4, 1'b1, "any_rise_captured");
        read_check(1, 2'd1, 32'h0, 1'b1, "any_reserved");
        bus_write(1, 2'd0, 32'hB);
        read_check(1, 2'd0, 32'h4, 1'b1, "any_data_write_ignored");

        // Reset mid-operation
        bus_write(0, 2'd2, 32'hF);
        pins_m = 4'hF;
        wait_clks(4);
        read_check(0, 2'd3, 32'h1, 1'b1, "pre_reset_cap");
        #2;
        reset = 1'b1;
        read_check(0, 2'd3, 32'h0, 1'b0, "midreset_cap");
        read_check(0, 2'd2, 32'h0, 1'b0, "midreset_mask");
        read_check(0, 2'd0, 32'h0, 1'b0, "midreset_data");
        @(negedge clk);
        reset = 1'b0;
        wait_clks(4);
        read_check(0, 2'd0, 32'hF, 1'b0, "rearm_data");
        read_check(0, 2'd3, 32'h0, 1'b0, "rearm_suppress");
        pins_m = 4'hE;
        wait_clks(4);
        pins_m = 4'hF;
        wait_clks(4);
        read_check(0, 2'd3, 32'h1, 1'b0, "rearmed_detects");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
